imem_boot_loader: RTL

//  Owns and sequences the instruction-memory port. It shares that port between the core's fetch path and a

---
 rtl/imem_boot_loader_pkg.sv | 21 ++
 rtl/imem_boot_loader_if.sv | 34 +++
 rtl/imem_boot_loader_word_packer.sv | 44 ++++
 rtl/imem_boot_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_ldr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ldr_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // Bits needed to hold any value 0..max_value inclusive.
    function automatic int count_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Loader-side bus bundle: the RX byte stream and the instruction RAM port.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // The loader consumes bytes and owns the RAM port.
    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    // Byte source and RAM side.
    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// Assembles 32-bit words from an LSB-first byte stream. Used for both the
// length header and the program data. word/word_valid include the byte
// presented in the current cycle, so the caller can register the finished
// word on the same edge that accepts its last byte.
module imem_word_packer
    import imem_ldr_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  data_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BYTE_CNT_W-1:0] cnt_reg;
    logic [31:0]           word_reg;
    logic [31:0]           word_next;

    assign word_valid = byte_en && !clear && (cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign word       = word_next;

    // Each byte lane takes the incoming byte when the counter points at it.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word_next[8*gi +: 8] = (byte_en && cnt_reg == BYTE_CNT_W'(gi))
                                        ? data_byte : word_reg[8*gi +: 8];
        end
    endgenerate

    // Byte counter and partial-word storage; a completed word starts fresh.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt_reg  <= '0;
            word_reg <= '0;
        end else if (byte_en) begin
            cnt_reg  <= cnt_reg + 1'b1;
            word_reg <= word_valid ? '0 : word_next;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory port owner: lets the core fetch while idle, and on a
// boot request holds the core, loads a length-prefixed LSB-first program
// from the byte stream into RAM starting at word 0, then releases the core.
module imem_boot_loader
    import imem_ldr_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int TIMEOUT_CYC = 100000,
    parameter bit BOOT_ON_RST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              boot_req_i,
    input  logic [31:0]       fetch_addr_i,
    output logic [31:0]       fetch_data_o,
    output logic              core_hold_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   words_loaded_o,
    imem_boot_loader_if.master bus
);

    localparam int          TO_W        = count_width(TIMEOUT_CYC);
    localparam logic [31:0] DEPTH_W32   = 32'(DEPTH);
    localparam logic [31:0] FETCH_LIMIT = 32'(4 * DEPTH);

    ldr_state_e        state_reg, state_next;
    logic [31:0]       n_reg, n_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [ADDR_W:0]   words_reg, words_next;
    logic [TO_W-1:0]   idle_reg, idle_next;

    logic              accept;
    logic              timed_out;
    logic              pk_clear;
    logic              pk_valid;
    logic [31:0]       pk_word;
    logic [ADDR_W-1:0] mem_addr_sel;
    logic              mem_we_sel;

    // Bytes are only taken while collecting header or data.
    assign bus.rx_ready = (state_reg == ST_HDR) || (state_reg == ST_DATA);
    assign accept       = bus.rx_valid && bus.rx_ready;
    // The idle count would reach TIMEOUT_CYC on this edge.
    assign timed_out    = !accept && (idle_reg == TO_W'(TIMEOUT_CYC - 1));

    imem_word_packer u_packer (
        .clk        (clk_i),
        .srst       (rst_i),
        .clear      (pk_clear),
        .byte_en    (accept),
        .data_byte  (bus.rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    // Next-state logic plus all port muxing and status outputs.
    always_comb begin
        state_next   = state_reg;
        n_next       = n_reg;
        wdata_next   = wdata_reg;
        words_next   = words_reg;
        idle_next    = '0;
        pk_clear     = 1'b0;
        mem_addr_sel = words_reg[ADDR_W-1:0];
        mem_we_sel   = 1'b0;
        fetch_data_o = '0;
        core_hold_o  = 1'b1;
        load_busy_o  = 1'b0;
        load_done_o  = 1'b0;
        load_err_o   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                core_hold_o  = 1'b0;
                mem_addr_sel = fetch_addr_i[ADDR_W+1:2];
                fetch_data_o = (fetch_addr_i < FETCH_LIMIT) ? bus.mem_rdata : '0;
                if (boot_req_i) begin
                    state_next = ST_HDR;
                    words_next = '0;
                    pk_clear   = 1'b1;
                end
            end
            ST_HDR: begin
                load_busy_o = 1'b1;
                idle_next   = accept ? '0 : idle_reg + 1'b1;
                if (pk_valid) begin
                    n_next = pk_word;
                    if (pk_word == 32'd0)
                        state_next = ST_DONE;
                    else if (pk_word > DEPTH_W32)
                        state_next = ST_ERR;
                    else
                        state_next = ST_DATA;
                end else if (timed_out) begin
                    state_next = ST_ERR;
                    pk_clear   = 1'b1;
                end
            end
            ST_DATA: begin
                load_busy_o = 1'b1;
                idle_next   = accept ? '0 : idle_reg + 1'b1;
                if (pk_valid) begin
                    wdata_next = pk_word;
                    state_next = ST_WRITE;
                end else if (timed_out) begin
                    state_next = ST_ERR;
                    pk_clear   = 1'b1;
                end
            end
            ST_WRITE: begin
                load_busy_o = 1'b1;
                mem_we_sel  = 1'b1;
                words_next  = words_reg + 1'b1;
                if ((32'(words_reg) + 32'd1) == n_reg)
                    state_next = ST_DONE;
                else
                    state_next = ST_DATA;
            end
            ST_DONE: begin
                load_done_o = 1'b1;
                state_next  = ST_IDLE;
            end
            ST_ERR: begin
                load_err_o = 1'b1;
                if (boot_req_i) begin
                    state_next = ST_HDR;
                    words_next = '0;
                    pk_clear   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.mem_addr    = mem_addr_sel;
    assign bus.mem_we      = mem_we_sel;
    assign bus.mem_wdata   = wdata_reg;
    assign words_loaded_o  = words_reg;

    // State, word count, latched length/data and idle-cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= BOOT_ON_RST ? ST_HDR : ST_IDLE;
            n_reg     <= '0;
            wdata_reg <= '0;
            words_reg <= '0;
            idle_reg  <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            wdata_reg <= wdata_next;
            words_reg <= words_next;
            idle_reg  <= idle_next;
        end
    end

endmodule
